// File: rtl/burst_mem_pkg.sv
// Shared constants, state encoding and helpers for the pmem burst responder.
package burst_mem_pkg;

  localparam int BURST_LEN  = 4;
  localparam int BEAT_BITS  = 64;
  localparam int LINE_BYTES = 32;
  localparam int OFFS_BITS  = $clog2(LINE_BYTES);
  localparam int LAT_BITS   = 4;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WAIT   = 3'd1,
    RBURST = 3'd2,
    WBURST = 3'd3,
    DONE   = 3'd4
  } burst_state_t;

  // True when the byte offset inside a line is zero.
  function automatic logic line_aligned(input logic [OFFS_BITS-1:0] offs);
    return (offs == {OFFS_BITS{1'b0}});
  endfunction

endpackage

// File: rtl/burst_mem_array.sv
// Word RAM: one synchronous write port, two combinational read ports.
// Contents are deliberately not reset so preloaded data survives rst.
module burst_mem_array
  import burst_mem_pkg::*;
#(
  parameter int ADDR_BITS = 10
) (
  input  logic                 clk,
  input  logic                 we_i,
  input  logic [ADDR_BITS-1:0] waddr_i,
  input  logic [BEAT_BITS-1:0] wdata_i,
  input  logic [ADDR_BITS-1:0] raddr_a_i,
  output logic [BEAT_BITS-1:0] rdata_a_o,
  input  logic [ADDR_BITS-1:0] raddr_b_i,
  output logic [BEAT_BITS-1:0] rdata_b_o
);

  logic [BEAT_BITS-1:0] mem_q [2**ADDR_BITS];

  // Single write port shared by burst writes and backdoor writes.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o = mem_q[raddr_a_i];
  assign rdata_b_o = mem_q[raddr_b_i];

endmodule

// File: rtl/burst_mem_responder.sv
// Physical-memory burst responder: serves line-aligned 256-bit requests as
// four 64-bit beats after LATENCY idle cycles, with a backdoor word port and
// a sticky protocol-error flag.
module burst_mem_responder
  import burst_mem_pkg::*;
#(
  parameter int LINE_IDX_BITS = 8,
  parameter int LATENCY       = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       pmem_read,
  input  logic                       pmem_write,
  input  logic [31:0]                pmem_address,
  input  logic [63:0]                pmem_wdata,
  output logic [63:0]                pmem_rdata,
  output logic                       pmem_resp,
  input  logic                       bd_we,
  input  logic [LINE_IDX_BITS+1:0]   bd_addr,
  input  logic [63:0]                bd_wdata,
  output logic [63:0]                bd_rdata,
  output logic                       busy,
  output logic                       protocol_err
);

  localparam int WORD_BITS = LINE_IDX_BITS + 2;
  localparam int ADDR_HI   = LINE_IDX_BITS + OFFS_BITS - 1;
  localparam logic [LAT_BITS-1:0] LAT_LAST  = LAT_BITS'((LATENCY > 0) ? (LATENCY - 1) : 0);
  localparam logic [1:0]          LAST_BEAT = 2'(BURST_LEN - 1);

  burst_state_t             state_q, state_d;
  logic [1:0]               beat_q, beat_d;
  logic [LAT_BITS-1:0]      lat_q, lat_d;
  logic [LINE_IDX_BITS-1:0] line_q, line_d;
  logic                     dir_wr_q, dir_wr_d;
  logic                     err_q, err_d;
  logic                     resp_q, resp_d;
  logic [63:0]              rdata_q, rdata_d;
  logic                     busy_q, busy_d;

  logic                     req_active_s;
  logic                     burst_we_s;
  logic                     mem_we_s;
  logic [WORD_BITS-1:0]     mem_waddr_s;
  logic [63:0]              mem_wdata_s;
  logic [WORD_BITS-1:0]     rd_idx_s;
  logic [63:0]              rd_word_s;
  logic                     unused_addr_s;

  // Address bits above the array size are ignored, so the address wraps.
  assign unused_addr_s = ^pmem_address[31:ADDR_HI+1];

  // Next-beat data is fetched one cycle early so the beat itself is a register.
  assign rd_idx_s = {line_d, beat_d};

  burst_mem_array #(
    .ADDR_BITS (WORD_BITS)
  ) u_array (
    .clk       (clk),
    .we_i      (mem_we_s),
    .waddr_i   (mem_waddr_s),
    .wdata_i   (mem_wdata_s),
    .raddr_a_i (rd_idx_s),
    .rdata_a_o (rd_word_s),
    .raddr_b_i (bd_addr),
    .rdata_b_o (bd_rdata)
  );

  // Write-port mux: burst beats own the port in WBURST, backdoor only in IDLE.
  always_comb begin
    burst_we_s = (state_q == WBURST) && pmem_write;
    if (burst_we_s) begin
      mem_we_s    = 1'b1;
      mem_waddr_s = {line_q, beat_q};
      mem_wdata_s = pmem_wdata;
    end else begin
      mem_we_s    = bd_we && (state_q == IDLE);
      mem_waddr_s = bd_addr;
      mem_wdata_s = bd_wdata;
    end
  end

  // Burst FSM: request acceptance, latency count, beat count, error capture.
  always_comb begin
    state_d      = state_q;
    beat_d       = beat_q;
    lat_d        = lat_q;
    line_d       = line_q;
    dir_wr_d     = dir_wr_q;
    err_d        = err_q;
    req_active_s = dir_wr_q ? pmem_write : pmem_read;

    case (state_q)
      IDLE: begin
        if (pmem_read || pmem_write) begin
          line_d   = pmem_address[ADDR_HI:OFFS_BITS];
          // Read wins when both directions are requested.
          dir_wr_d = pmem_write && !pmem_read;
          beat_d   = 2'd0;
          lat_d    = {LAT_BITS{1'b0}};
          if ((pmem_read && pmem_write) || !line_aligned(pmem_address[OFFS_BITS-1:0])) begin
            err_d = 1'b1;
          end else begin
            err_d = err_q;
          end
          if (LATENCY > 0) begin
            state_d = WAIT;
          end else if (dir_wr_d) begin
            state_d = WBURST;
          end else begin
            state_d = RBURST;
          end
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (!req_active_s) begin
          err_d   = 1'b1;
          lat_d   = {LAT_BITS{1'b0}};
          state_d = IDLE;
        end else if (lat_q == LAT_LAST) begin
          lat_d   = {LAT_BITS{1'b0}};
          state_d = dir_wr_q ? WBURST : RBURST;
        end else begin
          lat_d   = lat_q + LAT_BITS'(1);
        end
      end
      RBURST, WBURST: begin
        if (!req_active_s) begin
          err_d   = 1'b1;
          beat_d  = 2'd0;
          state_d = IDLE;
        end else if (beat_q == LAST_BEAT) begin
          beat_d  = 2'd0;
          state_d = DONE;
        end else begin
          beat_d  = beat_q + 2'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        beat_d  = 2'd0;
        lat_d   = {LAT_BITS{1'b0}};
      end
    endcase

    // Backdoor writes outside IDLE are dropped and flagged.
    if (bd_we && (state_q != IDLE)) begin
      err_d = 1'b1;
    end else begin
      err_d = err_d;
    end
  end

  // Output next-values derived from the next state so outputs are registered.
  always_comb begin
    resp_d = (state_d == RBURST) || (state_d == WBURST);
    busy_d = (state_d != IDLE);
    if (state_d == RBURST) begin
      rdata_d = rd_word_s;
    end else begin
      rdata_d = 64'd0;
    end
  end

  // State and output registers; reset aborts any burst in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      beat_q   <= 2'd0;
      lat_q    <= {LAT_BITS{1'b0}};
      line_q   <= {LINE_IDX_BITS{1'b0}};
      dir_wr_q <= 1'b0;
      err_q    <= 1'b0;
      resp_q   <= 1'b0;
      rdata_q  <= 64'd0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      beat_q   <= beat_d;
      lat_q    <= lat_d;
      line_q   <= line_d;
      dir_wr_q <= dir_wr_d;
      err_q    <= err_d;
      resp_q   <= resp_d;
      rdata_q  <= rdata_d;
      busy_q   <= busy_d;
    end
  end

  assign pmem_resp    = resp_q;
  assign pmem_rdata   = rdata_q;
  assign busy         = busy_q;
  assign protocol_err = err_q;

endmodule
